// File: rtl/op_scheduler_pkg.sv
// Shared types for op_scheduler: FSM states, ALU operation codes and the element-count clamp.
// The commit handshake is compiled in only when OP_SCHEDULER_COMMIT_EN is defined.
package op_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_COMMIT = 3'd4
   } sched_state_e;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_XOR = 2'd2,
      OP_AND = 2'd3
   } op_e;

   // A run never visits more elements than the memory holds.
   function automatic logic [31:0] clamp_count(input logic [31:0] count,
                                               input logic [31:0] depth);
      return (count > depth) ? depth : count;
   endfunction

endpackage

// File: rtl/op_alu.sv
// op_alu: combinational datapath for op_scheduler; ADD/SUB wrap to MEM_WIDTH bits.
module op_alu
   import op_scheduler_pkg::*;
#(
   parameter int MEM_WIDTH = 32
) (
   input  op_e                  op_i,
   input  logic [MEM_WIDTH-1:0] operand_a_i,
   input  logic [MEM_WIDTH-1:0] operand_b_i,
   output logic [MEM_WIDTH-1:0] result_o
);

   always_comb begin
      result_o = '0;
      case (op_i)
         OP_ADD:  result_o = operand_a_i + operand_b_i;
         OP_SUB:  result_o = operand_a_i - operand_b_i;
         OP_XOR:  result_o = operand_a_i ^ operand_b_i;
         OP_AND:  result_o = operand_a_i & operand_b_i;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/op_scheduler.sv
// op_scheduler: start/busy/done sequencer that fetches, computes, writes and (optionally)
// commits one result per element. Define OP_SCHEDULER_COMMIT_EN to enable the commit handshake.
module op_scheduler
   import op_scheduler_pkg::*;
#(
   parameter int  MEM_DEPTH = 8,
   parameter int  MEM_WIDTH = 32,
   localparam int AW        = $clog2(MEM_DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [AW-1:0]        base_i,
   input  logic [AW:0]          count_i,
   input  logic [1:0]           op_sel_i,
   output logic [AW-1:0]        operand1_addr_o,
   output logic [AW-1:0]        operand2_addr_o,
   input  logic [MEM_WIDTH-1:0] operand1_i,
   input  logic [MEM_WIDTH-1:0] operand2_i,
   output logic                 result_we_o,
   output logic [AW-1:0]        result_addr_o,
   output logic [MEM_WIDTH-1:0] result_o,
   output logic                 commit_valid_o,
   input  logic                 commit_ready_i,
   output logic [AW-1:0]        commit_addr_o,
   output logic [MEM_WIDTH-1:0] commit_data_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int CW = AW + 1;

   // Commit handshake: valid rises on entry to COMMIT and stays high with addr/data frozen
   // until the edge where ready is also high; ready while valid is low has no effect.

   sched_state_e         state_q, state_d;
   logic [AW-1:0]        idx_q, idx_d;
   logic [AW-1:0]        base_q, base_d;
   logic [CW-1:0]        count_q, count_d;
   op_e                  op_q, op_d;
   logic [MEM_WIDTH-1:0] opa_q, opa_d;
   logic [MEM_WIDTH-1:0] opb_q, opb_d;
   logic [MEM_WIDTH-1:0] result_q, result_d;
   logic [AW-1:0]        res_addr_q, res_addr_d;
   logic                 done_q, done_d;

   logic [CW-1:0]        count_clamped;
   logic [AW-1:0]        elem_addr;
   logic [MEM_WIDTH-1:0] alu_result;
   logic                 elem_accept;
   logic                 last_elem;

   assign count_clamped = CW'(clamp_count(32'(count_i), 32'(MEM_DEPTH)));
   assign elem_addr     = base_q + idx_q;
   assign last_elem     = (CW'(idx_q) + CW'(1)) >= count_q;

`ifdef OP_SCHEDULER_COMMIT_EN
   logic [AW-1:0]        cmt_addr_q, cmt_addr_d;
   logic [MEM_WIDTH-1:0] cmt_data_q, cmt_data_d;

   assign elem_accept = (state_q == ST_COMMIT) && commit_ready_i;
`else
   logic unused_commit_ready;

   assign unused_commit_ready = commit_ready_i;
   assign elem_accept         = (state_q == ST_WRITE);
`endif

   op_alu #(
      .MEM_WIDTH (MEM_WIDTH)
   ) u_alu (
      .op_i        (op_q),
      .operand_a_i (opa_q),
      .operand_b_i (opb_q),
      .result_o    (alu_result)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      base_d     = base_q;
      count_d    = count_q;
      op_d       = op_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      result_d   = result_q;
      res_addr_d = res_addr_q;
      done_d     = 1'b0;
`ifdef OP_SCHEDULER_COMMIT_EN
      cmt_addr_d = cmt_addr_q;
      cmt_data_d = cmt_data_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start_i && !abort_i) begin
               base_d  = base_i;
               count_d = count_clamped;
               op_d    = op_e'(op_sel_i);
               idx_d   = '0;
               if (count_clamped == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            opa_d   = operand1_i;
            opb_d   = operand2_i;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            result_d   = alu_result;
            res_addr_d = elem_addr;
            state_d    = ST_WRITE;
         end
         ST_WRITE: begin
`ifdef OP_SCHEDULER_COMMIT_EN
            cmt_addr_d = res_addr_q;
            cmt_data_d = result_q;
            state_d    = ST_COMMIT;
`endif
         end
         default: ;
      endcase

      // Element retirement: commit accepted, or write done when there is no checker.
      if (elem_accept) begin
         if (last_elem) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_FETCH;
         end
      end

      if (abort_i && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         base_q     <= '0;
         count_q    <= '0;
         op_q       <= OP_ADD;
         opa_q      <= '0;
         opb_q      <= '0;
         result_q   <= '0;
         res_addr_q <= '0;
         done_q     <= 1'b0;
`ifdef OP_SCHEDULER_COMMIT_EN
         cmt_addr_q <= '0;
         cmt_data_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         base_q     <= base_d;
         count_q    <= count_d;
         op_q       <= op_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         result_q   <= result_d;
         res_addr_q <= res_addr_d;
         done_q     <= done_d;
`ifdef OP_SCHEDULER_COMMIT_EN
         cmt_addr_q <= cmt_addr_d;
         cmt_data_q <= cmt_data_d;
`endif
      end
   end

   assign operand1_addr_o = elem_addr;
   assign operand2_addr_o = elem_addr;
   assign result_we_o     = (state_q == ST_WRITE);
   assign result_addr_o   = res_addr_q;
   assign result_o        = result_q;
   assign busy_o          = (state_q != ST_IDLE);
   assign done_o          = done_q;

`ifdef OP_SCHEDULER_COMMIT_EN
   assign commit_valid_o = (state_q == ST_COMMIT);
   assign commit_addr_o  = cmt_addr_q;
   assign commit_data_o  = cmt_data_q;
`else
   assign commit_valid_o = 1'b0;
   assign commit_addr_o  = '0;
   assign commit_data_o  = '0;
`endif

endmodule

// File: tb/tb_op_scheduler.sv
// tb_op_scheduler: directed and randomized runs checked against a queue-based reference model.
// Covers both builds of OP_SCHEDULER_COMMIT_EN.
module tb_op_scheduler;
  import op_scheduler_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int AW    = 3;
  localparam int EW    = AW + W;
`ifdef OP_SCHEDULER_COMMIT_EN
  localparam int L = 4;
`else
  localparam int L = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [AW-1:0] base_i = '0;
  logic [AW:0]   count_i = '0;
  logic [1:0]    op_sel_i = '0;
  logic [AW-1:0] operand1_addr_o, operand2_addr_o;
  logic [W-1:0]  operand1_i, operand2_i;
  logic          result_we_o;
  logic [AW-1:0] result_addr_o;
  logic [W-1:0]  result_o;
  logic          commit_valid_o;
  logic          commit_ready_i = 1'b1;
  logic [AW-1:0] commit_addr_o;
  logic [W-1:0]  commit_data_o;
  logic          busy_o, done_o;

  logic [W-1:0]  mem1 [DEPTH];
  logic [W-1:0]  mem2 [DEPTH];

  logic [EW-1:0] exp_w_q[$];
  logic [EW-1:0] exp_c_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int commits_seen = 0;
  int stall_elem = -1;
  int stall_left = 0;
  logic          hold_active = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic [W-1:0]  hold_data = '0;

  assign operand1_i = mem1[operand1_addr_o];
  assign operand2_i = mem2[operand2_addr_o];

  op_scheduler #(.MEM_DEPTH(DEPTH), .MEM_WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .base_i(base_i), .count_i(count_i), .op_sel_i(op_sel_i),
    .operand1_addr_o(operand1_addr_o), .operand2_addr_o(operand2_addr_o),
    .operand1_i(operand1_i), .operand2_i(operand2_i),
    .result_we_o(result_we_o), .result_addr_o(result_addr_o), .result_o(result_o),
    .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
    .commit_addr_o(commit_addr_o), .commit_data_o(commit_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a ^ b;
      default: return a & b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // scoreboard: sampled 1 time unit after each rising edge
  task automatic observe();
    logic [EW-1:0] e;
    if (result_we_o) begin
      if (exp_w_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        e = exp_w_q.pop_front();
        check("write_addr", 64'(result_addr_o), 64'(e[EW-1:W]));
        check("write_data", 64'(result_o), 64'(e[W-1:0]));
      end
    end
`ifdef OP_SCHEDULER_COMMIT_EN
    if (commit_valid_o) begin
      if (hold_active) begin
        check("hold_addr", 64'(commit_addr_o), 64'(hold_addr));
        check("hold_data", 64'(commit_data_o), 64'(hold_data));
      end
      if (stall_left > 0 && commits_seen == stall_elem) begin
        commit_ready_i = 1'b0;
        stall_left--;
        if (!hold_active) begin
          hold_active = 1'b1;
          hold_addr = commit_addr_o;
          hold_data = commit_data_o;
        end
      end else begin
        commit_ready_i = 1'b1;
        hold_active = 1'b0;
        commits_seen++;
        if (exp_c_q.size() == 0) check("unexpected_commit", 1, 0);
        else begin
          e = exp_c_q.pop_front();
          check("commit_addr", 64'(commit_addr_o), 64'(e[EW-1:W]));
          check("commit_data", 64'(commit_data_o), 64'(e[W-1:0]));
        end
      end
    end else begin
      if (hold_active) check("valid_dropped", 0, 1);
      hold_active = 1'b0;
      commit_ready_i = 1'b1;
    end
`else
    if (result_we_o) begin
      check("commit_valid_tied", 64'(commit_valid_o), 0);
      check("commit_addr_tied", 64'(commit_addr_o), 0);
      check("commit_data_tied", 64'(commit_data_o), 0);
    end
`endif
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    observe();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 0);
    check({tag, "_done"}, 64'(done_o), 0);
    check({tag, "_we"}, 64'(result_we_o), 0);
    check({tag, "_raddr"}, 64'(result_addr_o), 0);
    check({tag, "_rdata"}, 64'(result_o), 0);
    check({tag, "_op_addr"}, 64'({operand1_addr_o, operand2_addr_o}), 0);
    check({tag, "_cvalid"}, 64'(commit_valid_o), 0);
    check({tag, "_caddr"}, 64'(commit_addr_o), 0);
    check({tag, "_cdata"}, 64'(commit_data_o), 0);
  endtask

  // driver: queue the expected elements (up to limit), then pulse start for one edge
  task automatic start_run(input int base, input int cnt, input int op, input int limit);
    int n;
    logic [AW-1:0] a;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    if (n > limit) n = limit;
    for (int i = 0; i < n; i++) begin
      a = AW'((base + i) % DEPTH);
      exp_w_q.push_back({a, ref_op(op, mem1[a], mem2[a])});
      exp_c_q.push_back({a, ref_op(op, mem1[a], mem2[a])});
    end
    done_cnt = 0;
    commits_seen = 0;
    base_i = AW'(base);
    count_i = (AW+1)'(cnt);
    op_sel_i = 2'(op);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (done_cnt == 0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt), 1);
    check({tag, "_latency"}, 64'(done_cyc - c0), 64'(exp_lat));
    tick();
    check({tag, "_done_pulse"}, 64'(done_o), 0);
    check({tag, "_idle"}, 64'(busy_o), 0);
    check({tag, "_writes_left"}, 64'(exp_w_q.size()), 0);
`ifdef OP_SCHEDULER_COMMIT_EN
    check({tag, "_commits_left"}, 64'(exp_c_q.size()), 0);
`endif
    exp_c_q.delete();
  endtask

  initial begin
    int cnt, base, op, stall;
    logic trig;

    // reset
    tick();
    tick();
    check_zero_outputs("reset");
    rst_ni = 1'b1;
    tick();

    // basic ADD: 1, 12, 23, ... 78
    for (int i = 0; i < DEPTH; i++) begin
      mem1[i] = W'(i + 1);
      mem2[i] = W'(10 * i);
    end
    start_run(0, 8, 0, 99);
    check("add_busy", 64'(busy_o), 1);
    check("add_first_expected", 64'(exp_w_q[0][W-1:0]), 64'(1));
    wait_done("add", 8 * L);

    // wrap + SUB: 5 - 7 at 6,7,0,1
    for (int i = 0; i < DEPTH; i++) begin
      mem1[i] = 32'd5;
      mem2[i] = 32'd7;
    end
    start_run(6, 4, 1, 99);
    wait_done("wrap_sub", 4 * L);

    // backpressure at element 2
    for (int i = 0; i < DEPTH; i++) begin
      mem1[i] = $urandom();
      mem2[i] = $urandom();
    end
`ifdef OP_SCHEDULER_COMMIT_EN
    stall = 5;
    stall_elem = 2;
    stall_left = 5;
`else
    stall = 0;
`endif
    start_run(1, 6, 2, 99);
    wait_done("backpressure", 6 * L + stall);
    stall_elem = -1;

    // abort during EXEC of element 3
    start_run(0, 8, 3, 3);
    while (cyc < c0 + 3 * L + 1) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_idle", 64'(busy_o), 0);
    for (int i = 0; i < 10; i++) tick();
    check("abort_no_done", 64'(done_cnt), 0);
    check("abort_writes_left", 64'(exp_w_q.size()), 0);
    exp_c_q.delete();
    start_run(3, 5, 0, 99);
    wait_done("after_abort", 5 * L);

    // count = 0 and clamp
    start_run(4, 0, 0, 99);
    check("count0_done_next", 64'(done_o), 1);
    wait_done("count0", 0);
    start_run(5, 12, 2, 99);
    wait_done("clamp12", 8 * L);

    // start while busy is ignored
    start_run(2, 3, 1, 99);
    for (int i = 0; i < 4; i++) tick();
    base_i = 3'd5;
    count_i = 4'd1;
    op_sel_i = 2'd2;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done("start_busy", 3 * L);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem1[i] = $urandom();
        mem2[i] = $urandom();
      end
      cnt = $urandom_range(0, 12);
      base = $urandom_range(0, DEPTH - 1);
      op = $urandom_range(0, 3);
      start_run(base, cnt, op, 99);
      wait_done("random", L * ((cnt > DEPTH) ? DEPTH : cnt));
    end

    // reset mid-COMMIT (mid-WRITE without the handshake)
    start_run(2, 8, 0, 99);
    trig = 1'b0;
    for (int n = 0; n < 40 && !trig; n++) begin
      tick();
`ifdef OP_SCHEDULER_COMMIT_EN
      trig = commit_valid_o;
`else
      trig = result_we_o;
`endif
    end
    check("reset_trigger_seen", 64'(trig), 1);
    rst_ni = 1'b0;
    tick();
    check_zero_outputs("midrun_reset");
    rst_ni = 1'b1;
    exp_w_q.delete();
    exp_c_q.delete();
    done_cnt = 0;
    for (int i = 0; i < 6; i++) tick();
    check("midrun_reset_no_done", 64'(done_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
